uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that lets NUM_REQ byte requesters share
// one UART transmitter. Once a requester wins, it owns the transmitter until it
// has sent a byte flagged req_last, so bytes from different messages never mix.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/data/last per-requester byte offer (requester i on req_data[8i+7:8i])
//   req_ready           one-cycle accept pulse to the current owner
//   grant               one-hot current owner, zero when nobody owns the transmitter
//   tx_data, tx_start   byte and one-cycle start towards the transmitter
//   tx_busy             transmitter busy indication
//
// Build option: define UART_ARB_TIMEOUT_EN to release the lock when the owner
// stalls mid-message for TIMEOUT_CYCLES cycles. Without it the owner keeps the
// lock until it supplies its next byte.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [NUM_REQ-1:0]     grant,
    output logic [7:0]             tx_data,
    output logic                   tx_start,
    input  logic                   tx_busy
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_GRANT     = 3'd1;
    localparam logic [2:0] S_LOAD      = 3'd2;
    localparam logic [2:0] S_WAIT_ACK  = 3'd3;
    localparam logic [2:0] S_WAIT_DONE = 3'd4;
    localparam logic [2:0] S_HOLD      = 3'd5;

    logic [2:0]         state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   last_owner_q, last_owner_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               tx_start_q, tx_start_d;
    logic               last_flag_q, last_flag_d;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int unsigned     CNT_W    = 16;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    // Timeout depth has no effect when the timeout is compiled out.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^(32'(TIMEOUT_CYCLES));
`endif

    // Round-robin pick: first valid index strictly after last_owner, wrapping.
    logic             rr_found;
    logic [IDX_W-1:0] rr_idx;
    logic [IDX_W-1:0] rr_cand;
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        rr_cand  = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            rr_cand = IDX_W'((32'(last_owner_q) + k) % NUM_REQ);
            if (!rr_found && req_valid[rr_cand]) begin
                rr_found = 1'b1;
                rr_idx   = rr_cand;
            end
        end
    end

    // Current owner's offer.
    logic       owner_valid;
    logic       owner_last;
    logic [7:0] owner_byte;
    always_comb begin
        owner_valid = 1'b0;
        owner_last  = 1'b0;
        owner_byte  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (owner_q == IDX_W'(i)) begin
                owner_valid = req_valid[i];
                owner_last  = req_last[i];
                owner_byte  = req_data[8*i +: 8];
            end
        end
    end

    // Next-state and registered-output logic.
    logic load_go;
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        grant_d      = grant_q;
        req_ready_d  = '0;
        tx_start_d   = 1'b0;
        tx_data_d    = tx_data_q;
        last_flag_d  = last_flag_q;
        load_go      = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d        = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (rr_found) begin
                    owner_d = rr_idx;
                    grant_d = NUM_REQ'(1) << rr_idx;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                // A busy transmitter or an owner that withdrew keeps us here.
                if (!tx_busy && owner_valid) begin
                    load_go = 1'b1;
                end
            end
            S_LOAD: begin
                state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (tx_busy) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    if (last_flag_q) begin
                        grant_d      = '0;
                        last_owner_d = owner_q;
                        state_d      = S_IDLE;
                    end else begin
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (owner_valid) begin
                    load_go = 1'b1;
                end else begin
`ifdef UART_ARB_TIMEOUT_EN
                    if (cnt_q == CNT_LAST) begin
                        grant_d      = '0;
                        last_owner_d = owner_q;
                        cnt_d        = '0;
                        state_d      = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
`else
                    state_d = S_HOLD;
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Entering LOAD: accept the byte and issue tx_start in the same cycle.
        if (load_go) begin
            state_d     = S_LOAD;
            req_ready_d = grant_q;
            tx_start_d  = 1'b1;
            tx_data_d   = owner_byte;
            last_flag_d = owner_last;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_d       = '0;
`endif
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            owner_q      <= '0;
            last_owner_q <= IDX_W'(NUM_REQ - 1);
            grant_q      <= '0;
            req_ready_q  <= '0;
            tx_data_q    <= 8'h00;
            tx_start_q   <= 1'b0;
            last_flag_q  <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            grant_q      <= grant_d;
            req_ready_q  <= req_ready_d;
            tx_data_q    <= tx_data_d;
            tx_start_q   <= tx_start_d;
            last_flag_q  <= last_flag_d;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q        <= cnt_d;
`endif
        end
    end

    assign req_ready = req_ready_q;
    assign grant     = grant_q;
    assign tx_data   = tx_data_q;
    assign tx_start  = tx_start_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed latency/reset/busy scenarios followed by a
// randomized multi-requester run checked against a message-level round-robin
// model of the expected byte stream.
module tb_uart_tx_arbiter;

    localparam int unsigned N = 4;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   grant;
    logic [7:0]     tx_data;
    logic           tx_start;
    logic           tx_busy;

    int n_tests = 0;
    int n_fail  = 0;

    uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .grant     (grant),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_busy   (tx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic set_req(input int i, input bit v, input logic [7:0] d, input bit l);
        req_valid[i]       = v;
        req_data[8*i +: 8] = d;
        req_last[i]        = l;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_busy   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Random-run state
    logic [7:0] mem [N][32];
    bit         lst [N][32];
    int         len [N];
    int         ptr [N];
    int         stall [N];
    int         exp_owner [$];
    logic [7:0] exp_byte  [$];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        int hold;
        int busy_left;
        int last;
        int p [N];
        bit done;

        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_busy   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_grant",     32'(grant),     32'h0);
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_tx_start",  32'(tx_start),  32'h0);
        check("rst_tx_data",   32'(tx_data),   32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single-byte message from requester 0: grant at N+1, start at N+2.
        set_req(0, 1'b1, 8'h48, 1'b1);
        @(negedge clk);
        check("lat_grant",       32'(grant),    32'h1);
        check("lat_no_start_n1", 32'(tx_start), 32'h0);
        @(negedge clk);
        check("lat_start",     32'(tx_start),  32'h1);
        check("lat_req_ready", 32'(req_ready), 32'h1);
        check("lat_tx_data",   32'(tx_data),   32'h48);
        req_valid = '0;
        tx_busy   = 1'b1;
        @(negedge clk);
        check("start_pulse_one_cycle", 32'(tx_start),  32'h0);
        check("ready_pulse_one_cycle", 32'(req_ready), 32'h0);
        check("tx_data_stable",        32'(tx_data),   32'h48);
        repeat (4) @(negedge clk);
        tx_busy = 1'b0;
        @(negedge clk);
        check("single_byte_release", 32'(grant), 32'h0);

        // Transmitter busy from elsewhere: grant but no start until it frees.
        tx_busy = 1'b1;
        set_req(2, 1'b1, 8'hA5, 1'b1);
        @(negedge clk);
        check("busy_grant", 32'(grant), 32'h4);
        seen = 0;
        repeat (50) begin
            @(negedge clk);
            if (tx_start) seen++;
        end
        check("busy_blocks_start", 32'(seen), 32'h0);
        tx_busy = 1'b0;
        @(negedge clk);
        check("busy_fall_start",  32'(tx_start),  32'h1);
        check("busy_fall_data",   32'(tx_data),   32'hA5);
        check("busy_fall_ready",  32'(req_ready), 32'h4);
        req_valid = '0;
        tx_busy   = 1'b1;
        repeat (3) @(negedge clk);

        // Reset while waiting for the transmitter; afterwards requester 0 wins.
        set_req(0, 1'b1, 8'h30, 1'b1);
        set_req(3, 1'b1, 8'h33, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midrst_grant",     32'(grant),     32'h0);
        check("midrst_tx_start",  32'(tx_start),  32'h0);
        check("midrst_req_ready", 32'(req_ready), 32'h0);
        check("midrst_tx_data",   32'(tx_data),   32'h0);
        tx_busy = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_first_grant", 32'(grant), 32'h1);
        @(negedge clk);
        check("post_rst_first_byte", 32'(tx_data), 32'h30);

`ifdef UART_ARB_TIMEOUT_EN
        // Owner 0 stalls mid-message; lock released after 16 idle HOLD cycles.
        do_reset();
        set_req(0, 1'b1, 8'h11, 1'b0);
        set_req(3, 1'b1, 8'h33, 1'b1);
        @(negedge clk);
        @(negedge clk);
        check("to_first_ready", 32'(req_ready), 32'h1);
        req_valid[0] = 1'b0;
        tx_busy      = 1'b1;
        repeat (3) @(negedge clk);
        tx_busy = 1'b0;
        hold = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (grant == 4'b0001) hold++;
            else break;
        end
        check("to_hold_cycles", 32'(hold),  32'd16);
        check("to_released",    32'(grant), 32'h0);
        @(negedge clk);
        check("to_next_grant",  32'(grant), 32'h8);
`endif

        // Randomized run: every requester queues several messages up front.
        do_reset();
        for (int i = 0; i < N; i++) begin
            len[i]   = 0;
            ptr[i]   = 0;
            stall[i] = 0;
            for (int m = 0; m < int'($urandom_range(5, 2)); m++) begin
                int ml;
                ml = int'($urandom_range(4, 1));
                for (int b = 0; b < ml; b++) begin
                    mem[i][len[i]] = 8'($urandom);
                    lst[i][len[i]] = (b == ml - 1);
                    len[i]++;
                end
            end
        end
        // Expected stream: whole messages, owners chosen round-robin from 3.
        for (int i = 0; i < N; i++) p[i] = 0;
        last = N - 1;
        forever begin
            int pick;
            pick = -1;
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (last + k) % N;
                if (pick < 0 && p[c] < len[c]) pick = c;
            end
            if (pick < 0) break;
            forever begin
                bit endm;
                exp_owner.push_back(pick);
                exp_byte.push_back(mem[pick][p[pick]]);
                endm = lst[pick][p[pick]];
                p[pick]++;
                if (endm) break;
            end
            last = pick;
        end

        for (int i = 0; i < N; i++) begin
            set_req(i, ptr[i] < len[i], mem[i][0], lst[i][0]);
        end
        busy_left = 0;
        done      = 1'b0;
        for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
            @(negedge clk);
            if (req_ready != '0) check("rnd_ready_with_start", 32'(tx_start), 32'h1);
            if (tx_start) begin
                check("rnd_start_while_busy", 32'(tx_busy), 32'h0);
                if (exp_owner.size() == 0) begin
                    check("rnd_extra_start", 32'(tx_start), 32'h0);
                end else begin
                    check("rnd_owner_ready", 32'(req_ready), 32'(4'(1) << exp_owner[0]));
                    check("rnd_owner_grant", 32'(grant),     32'(4'(1) << exp_owner[0]));
                    check("rnd_byte",        32'(tx_data),   32'(exp_byte[0]));
                    void'(exp_owner.pop_front());
                    void'(exp_byte.pop_front());
                end
                busy_left = int'($urandom_range(10, 2));
                tx_busy   = 1'b1;
            end else if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) tx_busy = 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                if (req_ready[i]) begin
                    bit was_last;
                    was_last = lst[i][ptr[i]];
                    ptr[i]++;
                    if (!was_last && $urandom_range(2, 0) == 0) stall[i] = int'($urandom_range(8, 1));
                end else if (stall[i] > 0) begin
                    stall[i]--;
                end
                if (ptr[i] < len[i]) set_req(i, stall[i] == 0, mem[i][ptr[i]], lst[i][ptr[i]]);
                else                 set_req(i, 1'b0, 8'h00, 1'b0);
            end
            done = 1'b1;
            for (int i = 0; i < N; i++) if (ptr[i] < len[i]) done = 1'b0;
            if (exp_owner.size() != 0 || tx_busy) done = 1'b0;
        end
        check("rnd_drained", 32'(exp_owner.size()), 32'h0);
        repeat (3) @(negedge clk);
        check("rnd_final_grant", 32'(grant), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
